// File: rtl/led_pwm_pkg.sv
// Register map, CTRL field offsets and bus widths shared by the LED PWM controller.
package led_pwm_pkg;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int BLINK_P_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_BLINK  = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_DUTY0  = 5'd4;

  localparam int CTRL_EN_LSB    = 0;
  localparam int CTRL_BLINK_LSB = 16;

  function automatic logic [ADDR_W-1:0] duty_addr(input int i);
    return ADDR_DUTY0 + ADDR_W'(i);
  endfunction
endpackage

// File: rtl/led_pwm_if.sv
// Simple single-cycle register bus: sel/we/addr/wdata in, rdata/ready one cycle later.
interface led_pwm_if;
  import led_pwm_pkg::*;
  logic              sel;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output sel, we, addr, wdata, input rdata, ready);
  modport slave  (input sel, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow duty, period-aligned active duty, compare and registered drive.
module led_pwm_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [PWM_WIDTH-1:0] wdata,
    input  logic                 load,
    input  logic [PWM_WIDTH-1:0] cnt,
    input  logic                 en,
    output logic [PWM_WIDTH-1:0] shadow,
    output logic                 led
);
    logic [PWM_WIDTH-1:0] active;

    // Active duty only changes at the period boundary so a period is never torn.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
            led    <= 1'b0;
        end else begin
            if (wr)   shadow <= wdata;
            if (load) active <= shadow;
            led <= en && (cnt < active);
        end
    end
endmodule

// File: rtl/led_pwm_ctrl.sv
// LED PWM controller top: register bus, prescaler, PWM counter, per-LED channels.
// Optional blink gating is built only when LED_PWM_BLINK_EN is defined.
module led_pwm_ctrl #(
    parameter int NUM_LED   = 4,
    parameter int PWM_WIDTH = 8,
    parameter int PRESCALE  = 16
) (
    input  logic               clk,
    input  logic               reset,
    led_pwm_if.slave           bus,
    output logic [NUM_LED-1:0] led
);
    import led_pwm_pkg::*;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]                     presc;
    logic [PWM_WIDTH-1:0]                pwm_cnt;
    logic                                tick, wrap, wr;
    logic [NUM_LED-1:0]                  en, ch_en, duty_wr;
    logic [NUM_LED-1:0][PWM_WIDTH-1:0]   shadow;
    logic [DATA_W-1:0]                   rd;
    logic                                unused_wdata;

    assign tick         = (presc == PS_W'(PRESCALE - 1));
    assign wrap         = tick && (pwm_cnt == '1);
    assign wr           = bus.sel && bus.we;
    assign unused_wdata = ^bus.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            presc   <= presc + 1'b1;
        end
    end

`ifdef LED_PWM_BLINK_EN
    logic [NUM_LED-1:0]   bmask;
    logic [BLINK_P_W-1:0] bper, bcnt;
    logic                 blink_off;

    // blink_off=0 is the visible phase; a zero period parks it there.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt      <= '0;
            blink_off <= 1'b0;
        end else if (wrap) begin
            if (bper == '0) begin
                bcnt      <= '0;
                blink_off <= 1'b0;
            end else if (bcnt >= bper - 1'b1) begin
                bcnt      <= '0;
                blink_off <= ~blink_off;
            end else begin
                bcnt      <= bcnt + 1'b1;
            end
        end
    end

    assign ch_en = en & ~(bmask & {NUM_LED{blink_off}});
`else
    assign ch_en = en;
`endif

    always_comb begin
        rd = '0;
        case (bus.addr)
            ADDR_CTRL: begin
                rd[CTRL_EN_LSB +: NUM_LED] = en;
`ifdef LED_PWM_BLINK_EN
                rd[CTRL_BLINK_LSB +: NUM_LED] = bmask;
`endif
            end
            ADDR_BLINK: begin
`ifdef LED_PWM_BLINK_EN
                rd[BLINK_P_W-1:0] = bper;
`endif
            end
            ADDR_STATUS: rd[PWM_WIDTH-1:0] = pwm_cnt;
            default: begin
                for (int i = 0; i < NUM_LED; i++)
                    if (bus.addr == duty_addr(i)) rd[PWM_WIDTH-1:0] = shadow[i];
            end
        endcase
    end

    // Reset wins over a same-cycle access: no commit, no ready pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            en        <= '0;
`ifdef LED_PWM_BLINK_EN
            bmask     <= '0;
            bper      <= '0;
`endif
        end else begin
            bus.ready <= bus.sel;
            bus.rdata <= (bus.sel && !bus.we) ? rd : '0;
            if (wr) begin
                case (bus.addr)
                    ADDR_CTRL: begin
                        en <= bus.wdata[CTRL_EN_LSB +: NUM_LED];
`ifdef LED_PWM_BLINK_EN
                        bmask <= bus.wdata[CTRL_BLINK_LSB +: NUM_LED];
`endif
                    end
`ifdef LED_PWM_BLINK_EN
                    ADDR_BLINK: bper <= bus.wdata[BLINK_P_W-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
        assign duty_wr[i] = wr && (bus.addr == duty_addr(i));
        led_pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .wr     (duty_wr[i]),
            .wdata  (bus.wdata[PWM_WIDTH-1:0]),
            .load   (wrap),
            .cnt    (pwm_cnt),
            .en     (ch_en[i]),
            .shadow (shadow[i]),
            .led    (led[i])
        );
    end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl (NUM_LED=4, PWM_WIDTH=8, PRESCALE=1).
module tb_led_pwm_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] led;
    led_pwm_if  bus();

    led_pwm_ctrl #(.NUM_LED(4), .PWM_WIDTH(8), .PRESCALE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .led   (led)
    );

    always #5 clk = ~clk;

    typedef struct { string tag; logic [31:0] val; } exp_t;
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   mcnt, wcnt;
    logic sel_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference period position: PRESCALE=1 so the counter steps every cycle.
    always @(posedge clk) begin
        if (reset) begin
            mcnt <= 0;
            wcnt <= 0;
        end else begin
            mcnt <= (mcnt + 1) % 256;
            if (mcnt == 255) wcnt <= wcnt + 1;
        end
        sel_d <= bus.sel && !reset;
    end

    always @(negedge clk) begin
        exp_t e;
        chk("ready_timing", {31'd0, bus.ready}, {31'd0, sel_d});
        if (bus.ready) begin
            if (exp_q.size() == 0) chk("sb_empty_on_ready", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                chk(e.tag, bus.rdata, e.val);
            end
        end else begin
            chk("rdata_idle", bus.rdata, 32'd0);
        end
    end

    task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] e, input string tag);
        exp_t x;
        @(negedge clk);
        bus.sel = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        x.tag = tag; x.val = w ? 32'd0 : e;
        exp_q.push_back(x);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        issue(1'b1, a, d, 32'd0, "write_rdata");
        idle();
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
        issue(1'b0, a, 32'd0, e, tag);
        idle();
    endtask

    task automatic rd_status();
        exp_t x;
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 5'd2;
        x.tag = "status"; x.val = 32'(mcnt);
        exp_q.push_back(x);
        idle();
    endtask

    task automatic wait_cnt(input int m);
        int k = 0;
        do begin @(negedge clk); k++; end while (mcnt != m && k < 600);
        if (k >= 600) chk("wait_cnt_timeout", 32'(k), 32'd0);
    endtask

    task automatic count_win(input int n, output int c0, output int c1, output int c2, output int c3);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c0 += int'(led[0]); c1 += int'(led[1]); c2 += int'(led[2]); c3 += int'(led[3]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, c3;
        reset = 1'b1;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_led", {28'd0, led}, 32'd0);
        reset = 1'b0;

        rd(5'd0, 32'd0, "ctrl_reset");
        rd(5'd4, 32'd0, "duty0_reset");
        rd_status();

        // Blink fields, upper bits, unmapped addresses.
        wr(5'd0, 32'hFFFF_FFFF);
`ifdef LED_PWM_BLINK_EN
        rd(5'd0, 32'h000F_000F, "ctrl_upper_bits");
        wr(5'd1, 32'h0000_0005);
        rd(5'd1, 32'h0000_0005, "blink_reg");
`else
        rd(5'd0, 32'h0000_000F, "ctrl_upper_bits");
        wr(5'd1, 32'h0000_0005);
        rd(5'd1, 32'h0000_0000, "blink_absent");
`endif
        wr(5'd1, 32'd0);
        wr(5'd0, 32'd0);
        wr(5'h1F, 32'h5A);
        rd(5'h1F, 32'd0, "unmapped_1f");
        wr(5'd3, 32'h77);
        rd(5'd3, 32'd0, "unmapped_3");
        wr(5'd6, 32'hFFFF_FF05);
        rd(5'd6, 32'h05, "duty2_upper");
        rd(5'd0, 32'd0, "ctrl_after_ignored");

        // CTRL=1, DUTY0=0x40: dark until the next wrap, then 64/256.
        wr(5'd0, 32'h1);
        wait_cnt(8'h20);
        wr(5'd4, 32'h40);
        count_win(150, c0, c1, c2, c3);
        chk("duty0_before_wrap", 32'(c0), 32'd0);
        wait_cnt(1);
        count_win(256, c0, c1, c2, c3);
        chk("duty0_40_high", 32'(c0), 32'd64);
        chk("led31_off", 32'(c1 + c2 + c3), 32'd0);

        // Mixed duties incl. 0x00 and 0xFF.
        wait_cnt(8'h80);
        wr(5'd0, 32'hF);
        wr(5'd5, 32'h20);
        wr(5'd6, 32'h00);
        wr(5'd7, 32'hFF);
        wait_cnt(1);
        count_win(256, c0, c1, c2, c3);
        chk("duty0_steady", 32'(c0), 32'd64);
        chk("duty1_20_high", 32'(c1), 32'd32);
        chk("duty2_00_high", 32'(c2), 32'd0);
        chk("duty3_ff_high", 32'(c3), 32'd255);

        // Mid-period duty write must not take effect before the wrap.
        wait_cnt(8'h10);
        wr(5'd5, 32'h80);
        rd(5'd5, 32'h80, "duty1_shadow_read");
        wait_cnt(8'h48);
        count_win(168, c0, c1, c2, c3);
        chk("duty1_old_kept", 32'(c1), 32'd0);
        wait_cnt(1);
        count_win(256, c0, c1, c2, c3);
        chk("duty1_80_high", 32'(c1), 32'd128);

        // Disable clears led on the following cycle.
        wr(5'd0, 32'h7);
        chk("led3_before_disable", {31'd0, led[3]}, 32'd1);
        @(negedge clk);
        chk("led3_disabled", {31'd0, led[3]}, 32'd0);

        // Back-to-back reads.
        wr(5'd4, 32'hAB);
        issue(1'b0, 5'd4, 32'd0, 32'hAB, "duty0_ab");
        issue(1'b0, 5'h1F, 32'd0, 32'd0, "unmapped_b2b");
        idle();

        // Reset over a pending ready and a same-cycle write.
        wait_cnt(8'h60);
        issue(1'b0, 5'd0, 32'd0, 32'h7, "ctrl_pre_reset");
        @(negedge clk);
        reset = 1'b1; bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 5'd4; bus.wdata = 32'h55;
        @(negedge clk);
        reset = 1'b0; bus.sel = 1'b0; bus.we = 1'b0;
        chk("reset_led_mid", {28'd0, led}, 32'd0);
        chk("reset_ready", {31'd0, bus.ready}, 32'd0);
        rd(5'd4, 32'd0, "duty0_not_committed");
        rd(5'd0, 32'd0, "ctrl_cleared");

`ifdef LED_PWM_BLINK_EN
        wr(5'd1, 32'd2);
        wr(5'd0, 32'h0001_0001);
        wr(5'd4, 32'hFF);
        begin
            int k = 0;
            while (!(wcnt == 4 && mcnt == 0) && k < 3000) begin @(negedge clk); k++; end
            if (k >= 3000) chk("blink_wait_timeout", 32'(k), 32'd0);
        end
        count_win(256, c0, c1, c2, c3);
        chk("blink_p4_on", 32'(c0), 32'd255);
        count_win(256, c0, c1, c2, c3);
        chk("blink_p5_on", 32'(c0), 32'd255);
        count_win(256, c0, c1, c2, c3);
        chk("blink_p6_off", 32'(c0), 32'd0);
        count_win(256, c0, c1, c2, c3);
        chk("blink_p7_off", 32'(c0), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
